// File: rtl/prog_sequencer.sv
// Program-counter and fetch sequencer: arms at ProgBase on Start, steps or branches
// the PC while running, stops on Halt and counts retired instructions.
module prog_sequencer #(
    parameter int PW = 10,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] ProgBase,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchTaken,
    input  logic [PW-1:0] BranchTarget,
    output logic [PW-1:0] PC,
    output logic          Valid,
    output logic          Done,
    output logic [CW-1:0] InstrCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seqState_t;

    seqState_t     state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Start re-arms from any state; otherwise only an unstalled RUN cycle retires.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (Start) begin
            state_d = ARM;
            pc_d    = ProgBase;
            count_d = '0;
        end else begin
            case (state_q)
                ARM: state_d = RUN;
                RUN: begin
                    if (!Stall) begin
                        if (count_q != {CW{1'b1}}) begin
                            count_d = count_q + 1'b1;
                        end
                        if (Halt) begin
                            state_d = DONE;
                        end else if (BranchTaken) begin
                            pc_d = BranchTarget;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign PC         = pc_q;
    assign Valid      = (state_q == RUN);
    assign Done       = (state_q == DONE);
    assign InstrCount = count_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed program scenarios followed by
// randomized traffic, all compared against a behavioural model of the sequencer.
module tb_prog_sequencer;

    localparam int PW   = 10;
    localparam int CW   = 5;
    localparam int PMOD = 1 << PW;
    localparam int CMAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic [PW-1:0] ProgBase = '0;
    logic          Stall = 1'b0;
    logic          Halt = 1'b0;
    logic          BranchTaken = 1'b0;
    logic [PW-1:0] BranchTarget = '0;
    logic [PW-1:0] PC;
    logic          Valid;
    logic          Done;
    logic [CW-1:0] InstrCount;

    int checks = 0;
    int errors = 0;

    // Model: "armed" means one cycle since Start dropped is still pending,
    // "running" means instructions retire, "finished" means Halt was retired.
    bit mArmed, mRunning, mFinished;
    int mPc, mCount;

    prog_sequencer #(.PW(PW), .CW(CW)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .ProgBase(ProgBase),
        .Stall(Stall),
        .Halt(Halt),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .PC(PC),
        .Valid(Valid),
        .Done(Done),
        .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input bit rst, input bit start, input int base,
                                 input bit stall, input bit halt, input bit br,
                                 input int tgt);
        Reset        = rst;
        Start        = start;
        ProgBase     = base[PW-1:0];
        Stall        = stall;
        Halt         = halt;
        BranchTaken  = br;
        BranchTarget = tgt[PW-1:0];
        @(posedge Clk);
        if (rst) begin
            mArmed = 0; mRunning = 0; mFinished = 0; mPc = 0; mCount = 0;
        end else if (start) begin
            mArmed = 1; mRunning = 0; mFinished = 0; mPc = base % PMOD; mCount = 0;
        end else if (mArmed) begin
            mArmed = 0; mRunning = 1;
        end else if (mRunning && !stall) begin
            mCount = (mCount >= CMAX) ? CMAX : mCount + 1;
            if (halt) begin
                mRunning  = 0;
                mFinished = 1;
            end else if (br) begin
                mPc = tgt % PMOD;
            end else begin
                mPc = (mPc + 1) % PMOD;
            end
        end
        #1;
        checkOutput("pc", 32'(PC), 32'(mPc));
        checkOutput("valid", 32'(Valid), 32'(mRunning));
        checkOutput("done", 32'(Done), 32'(mFinished));
        checkOutput("count", 32'(InstrCount), 32'(mCount));
    endtask

    task automatic runPlain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic armAt(input int base);
        applyStimulus(0, 1, base, 0, 0, 0, 0);
        applyStimulus(0, 1, base, 0, 0, 0, 0);
        applyStimulus(0, 0, base, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("resetPc", 32'(PC), 32'h0);
        checkOutput("resetValid", 32'(Valid), 32'h0);

        // Arm and run from 0x040
        armAt(12'h040);
        checkOutput("firstFetchPc", 32'(PC), 32'h040);
        checkOutput("firstFetchValid", 32'(Valid), 32'h1);
        runPlain(2);
        checkOutput("runPc", 32'(PC), 32'h042);
        checkOutput("runCount", 32'(InstrCount), 32'd2);

        // Branch to 0x010
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h010);
        checkOutput("branchPc", 32'(PC), 32'h010);
        checkOutput("branchCount", 32'(InstrCount), 32'd3);
        runPlain(1);

        // Stall ignores Halt and BranchTaken
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 1, 12'h2AA);
        checkOutput("stallPc", 32'(PC), 32'h011);
        checkOutput("stallValid", 32'(Valid), 32'h1);
        runPlain(1);
        checkOutput("postStallPc", 32'(PC), 32'h012);

        // Address wrap
        armAt(12'h3FF);
        runPlain(1);
        checkOutput("wrapPc", 32'(PC), 32'h000);
        checkOutput("wrapCount", 32'(InstrCount), 32'd1);

        // Halt has priority over branch, Done holds until Start
        armAt(12'h003);
        runPlain(2);
        applyStimulus(0, 0, 0, 0, 1, 1, 12'h100);
        checkOutput("haltDone", 32'(Done), 32'h1);
        checkOutput("haltPc", 32'(PC), 32'h005);
        checkOutput("haltCount", 32'(InstrCount), 32'd3);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, i[0], i[1], 1, 12'h100);
        applyStimulus(0, 1, 12'h200, 0, 0, 0, 0);
        checkOutput("rearmDone", 32'(Done), 32'h0);
        checkOutput("rearmPc", 32'(PC), 32'h200);

        // Reset mid-run with Start high
        armAt(12'h11C);
        runPlain(7);
        checkOutput("preResetPc", 32'(PC), 32'h123);
        applyStimulus(1, 1, 12'h0AB, 0, 0, 0, 0);
        checkOutput("midResetCount", 32'(InstrCount), 32'h0);
        checkOutput("midResetValid", 32'(Valid), 32'h0);
        runPlain(2);

        // Count saturation in a long run
        armAt(12'h300);
        runPlain(CMAX + 5);
        checkOutput("satCount", 32'(InstrCount), 32'(CMAX));

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit rst, start, stall, halt, br;
            int base;
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 3) == 0);
            halt  = ($urandom_range(0, 29) == 0);
            br    = ($urandom_range(0, 5) == 0);
            base  = ($urandom_range(0, 7) == 0) ? 12'h3FF : int'($urandom_range(0, PMOD - 1));
            applyStimulus(rst, start, base, stall, halt, br,
                          int'($urandom_range(0, PMOD - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
